// File: rtl/bullet_slot_arbiter_pkg.sv
// rtl/bullet_slot_arbiter_pkg.sv - shared sizing defaults and FSM encoding for the bullet slot arbiter
package bullet_slot_arbiter_pkg;

   localparam int DEF_NREQ     = 4;
   localparam int DEF_NSLOT    = 4;
   localparam int DEF_REQ_ID_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/bullet_slot_arbiter_free_slot_encoder.sv
// rtl/bullet_slot_arbiter_free_slot_encoder.sv - lowest-index free bullet slot finder
module bullet_slot_arbiter_free_slot_encoder
   import bullet_slot_arbiter_pkg::*;
#(
   parameter int NSLOT  = DEF_NSLOT,
   parameter int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
   input  logic [NSLOT-1:0]  slot_busy,
   output logic [SLOT_W-1:0] slot_idx,
   output logic              any_free
);

   // Walk downward so the last hit written is the lowest free index.
   always_comb begin
      slot_idx = '0;
      any_free = 1'b0;
      for (int s = NSLOT - 1; s >= 0; s--) begin
         if (!slot_busy[s]) begin
            slot_idx = SLOT_W'(s);
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bullet_slot_arbiter.sv
// rtl/bullet_slot_arbiter.sv - round-robin fire request to bullet slot arbiter
// Optional macro PLAYER_PRIORITY_EN: requester 0 is examined first in every scan.
module bullet_slot_arbiter
   import bullet_slot_arbiter_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int NSLOT    = DEF_NSLOT,
   parameter int REQ_ID_W = DEF_REQ_ID_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enb,
   input  logic                pixel_0_line_0,
   input  logic [NREQ-1:0]     req,
   input  logic [NSLOT-1:0]    slot_done,
   output logic [NSLOT-1:0]    launch,
   output logic [REQ_ID_W-1:0] launch_owner,
   output logic [NSLOT-1:0]    slot_busy,
   output logic [NREQ-1:0]     dropped,
   output logic                busy
);

   localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam logic [REQ_ID_W-1:0] LAST_ID = REQ_ID_W'(NREQ - 1);

   state_t              state, state_nxt;
   logic [NREQ-1:0]     pending, pending_nxt;
   logic [NSLOT-1:0]    slot_busy_nxt, launch_nxt, slot_set;
   logic [NREQ-1:0]     dropped_nxt, grant_vec, cap;
   logic [REQ_ID_W-1:0] idx, idx_nxt, cnt, cnt_nxt, rr_ptr, rr_nxt;
   logic [REQ_ID_W-1:0] last_grant, last_nxt, owner_nxt, start_idx;
   logic                granted_any, any_nxt, grant;
   logic [SLOT_W-1:0]   free_idx;
   logic                any_free;
   logic [NSLOT-1:0]    free_onehot;

   bullet_slot_arbiter_free_slot_encoder #(
      .NSLOT  (NSLOT),
      .SLOT_W (SLOT_W)
   ) u_free_slot_encoder (
      .slot_busy (slot_busy),
      .slot_idx  (free_idx),
      .any_free  (any_free)
   );

   assign free_onehot = NSLOT'(1) << free_idx;
   assign busy        = (state == SCAN);

`ifdef PLAYER_PRIORITY_EN
   assign start_idx = '0;
`else
   assign start_idx = rr_ptr;
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      rr_nxt    = rr_ptr;
      last_nxt  = last_grant;
      any_nxt   = granted_any;
      launch_nxt = '0;
      owner_nxt  = '0;
      grant      = 1'b0;
      grant_vec  = '0;
      slot_set   = '0;
      case (state)
         IDLE: begin
            if (enb && pixel_0_line_0 && (|pending) && any_free) begin
               state_nxt = SCAN;
               idx_nxt   = start_idx;
               cnt_nxt   = '0;
               any_nxt   = 1'b0;
            end
         end
         SCAN: begin
            if (enb) begin
               if (pending[idx] && any_free) begin
                  grant          = 1'b1;
                  grant_vec[idx] = 1'b1;
                  slot_set       = free_onehot;
                  launch_nxt     = free_onehot;
                  owner_nxt      = idx;
                  last_nxt       = idx;
                  any_nxt        = 1'b1;
               end
`ifdef PLAYER_PRIORITY_EN
               // After the cannon, rotate over 1..NREQ-1 starting at rr_ptr.
               if (idx == '0)
                  idx_nxt = (rr_ptr == '0) ? REQ_ID_W'(1) : rr_ptr;
               else
                  idx_nxt = (idx == LAST_ID) ? REQ_ID_W'(1) : idx + 1'b1;
`else
               idx_nxt = (idx == LAST_ID) ? '0 : idx + 1'b1;
`endif
               cnt_nxt = cnt + 1'b1;
               if (cnt == LAST_ID || (grant && (&(slot_busy | free_onehot)))) begin
                  state_nxt = IDLE;
                  if (any_nxt)
                     rr_nxt = (last_nxt == LAST_ID) ? '0 : last_nxt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A request landing on the grant cycle re-arms pending without a drop.
   assign cap           = enb ? req : '0;
   assign pending_nxt   = (pending & ~grant_vec) | cap;
   assign dropped_nxt   = cap & pending & ~grant_vec;
   assign slot_busy_nxt = (slot_busy & ~slot_done) | slot_set;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pending      <= '0;
         slot_busy    <= '0;
         rr_ptr       <= '0;
         idx          <= '0;
         cnt          <= '0;
         last_grant   <= '0;
         granted_any  <= 1'b0;
         launch       <= '0;
         launch_owner <= '0;
         dropped      <= '0;
      end else begin
         state        <= state_nxt;
         pending      <= pending_nxt;
         slot_busy    <= slot_busy_nxt;
         rr_ptr       <= rr_nxt;
         idx          <= idx_nxt;
         cnt          <= cnt_nxt;
         last_grant   <= last_nxt;
         granted_any  <= any_nxt;
         launch       <= launch_nxt;
         launch_owner <= owner_nxt;
         dropped      <= dropped_nxt;
      end
   end

endmodule

// File: doc/bullet_slot_arbiter.md
Name: bullet_slot_arbiter

Overview:
Shares a fixed pool of bullet slots between several fire requesters: the player cannon and the alien shooters, each a fire-pulse source with its own cooldown. Captures fire pulses as pending requests. On each frame tick it scans the requesters round-robin and launches each granted requester into the lowest free slot. Sits between the fire pulse sources and the bullet motion/render units; each bullet unit reports retirement back via slot_done.

Parameters:
NREQ, 4, number of requesters; requester 0 is the player cannon.
NSLOT, 4, number of bullet slots.
REQ_ID_W, 2, width of requester id; must satisfy 2**REQ_ID_W >= NREQ.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
enb  in  1  game-run enable; 0 = paused.
pixel_0_line_0  in  1  frame tick: one-cycle pulse at pixel 0, line 0.
req  in  NREQ  fire pulses, one bit per requester.
slot_done  in  NSLOT  one-cycle pulse when a bullet slot retires (hit or off-screen).
launch  out  NSLOT  one-hot, one-cycle pulse that starts a bullet in a slot.
launch_owner  out  REQ_ID_W  id of the requester owning the current launch; valid while launch != 0.
slot_busy  out  NSLOT  slot occupancy vector.
dropped  out  NREQ  one-cycle pulse per requester whose fire request was discarded.
busy  out  1  high while the FSM is in SCAN.

Behaviour:
- Reset (sync, rst=1 at posedge): pending=0, slot_busy=0, rr_ptr=0, idx=0, cnt=0, FSM=IDLE; launch=0, launch_owner=0, dropped=0, busy=0. Applies immediately mid-SCAN; no launch is issued on the following cycle.
- Pending capture (requires enb=1):
  - req[i]=1 sets pending[i].
  - If pending[i] is already set, dropped[i] pulses on the next cycle and pending[i] stays 1.
  - If req[i] arrives in the same cycle that requester i is granted, pending[i] ends at 1 and no drop is signalled.
- Slot release: slot_done[s] clears slot_busy[s] regardless of enb. slot_done on a slot that is already free is ignored.
- FSM states:
  - IDLE: on enb && pixel_0_line_0 && |pending && |~slot_busy, go to SCAN with idx=rr_ptr, cnt=0. Otherwise hold.
  - SCAN: busy=1. On each cycle with enb=1, examine requester idx:
    - If pending[idx] and a free slot exists, let s = lowest-index free slot. At the next edge: launch=1<<s, launch_owner=idx, slot_busy[s]=1, pending[idx]=0, last_grant=idx.
    - Then idx=(idx+1) mod NREQ and cnt=cnt+1.
    - Go to IDLE after cnt reaches NREQ-1 (all requesters examined once), or when the grant in this cycle used the last free slot.
    - On exit, rr_ptr=(last_grant+1) mod NREQ if any grant occurred in this scan; otherwise rr_ptr is unchanged.
  - enb=0 during SCAN: hold state, idx and cnt; launch=0; resume when enb returns.
- The free-slot vector is evaluated every cycle, so a slot_done received during SCAN makes that slot grantable on the next examined cycle.
- A frame tick arriving during SCAN is ignored.
- Scan latency is at most NREQ cycles after the tick, and at most one launch occurs per cycle.
- launch and dropped are registered outputs and are 0 in every cycle they are not pulsed.

Optional Feature:
PLAYER_PRIORITY_EN:
- Defined: SCAN always examines requester 0 first (player cannon), then continues round-robin from rr_ptr over requesters 1..NREQ-1, skipping 0. The scan takes at most NREQ cycles.
- Undefined: pure round-robin; requester 0 is treated like any other requester.

Decomposition:
- Shared define file holds NREQ, NSLOT, REQ_ID_W defaults and the FSM state encodings IDLE=1'b0 and SCAN=1'b1.
- One sub-module, free_slot_encoder: combinational lowest-index-zero finder over slot_busy, producing slot index and an any_free flag.

Test Plan:
- Reset, then req=4'b0001, then a frame tick -> launch=4'b0001 and launch_owner=0 within 2 cycles; slot_busy=4'b0001; pending[0] cleared.
- req=4'b1111 with all slots free, then a tick -> four launches on consecutive cycles to slots 0,1,2,3 with owners 0,1,2,3; FSM returns to IDLE; rr_ptr=0.
- slot_busy=4'b0111 and pending=4'b0110, then a tick -> only requester 1 launches, into slot 3; requester 2 stays pending; the next tick grants requester 2 after a slot_done.
- Two req[2] pulses before any tick -> dropped[2] pulses once; pending[2]=1.
- rst asserted in the second SCAN cycle of a 4-request scan -> no further launch; all outputs 0 on the next cycle.
- enb=0 held for 3 cycles mid-SCAN -> launch stays 0 and idx is held; remaining grants resume identically once enb=1. With PLAYER_PRIORITY_EN and rr_ptr=2, pending=1111 -> owner order 0,2,3,1.
